// File: rtl/ipd_multicanal.sv
// Time-multiplexed multi-channel I-PD controller.
// One multiplier set swept over CH channels per sample tick.
module ipd_multicanal #(
  parameter int N    = 18,
  parameter int FRAC = 0,
  parameter int CH   = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sample_en,
  input  logic [CH*N-1:0]     ref_in,
  input  logic [CH*N-1:0]     y_in,
  input  logic signed [N-1:0] kp,
  input  logic signed [N-1:0] ki,
  input  logic signed [N-1:0] kd,
  input  logic signed [N-1:0] out_max,
  input  logic signed [N-1:0] out_min,
  output logic [CH*N-1:0]     ipd_out,
  output logic                out_valid,
  output logic                busy,
  output logic                overrun
);

  localparam int W  = 2*N+4;
  localparam int CW = (CH > 1) ? $clog2(CH) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CAPT, S_MUL, S_ACC, S_DONE
  } state_t;

  state_t r_state, w_next;

  logic r_s1, r_s2, r_filt, r_filt_q;
  logic w_tick;

  logic [CW-1:0] r_ch;
  logic          r_primed;

  logic signed [N-1:0] r_ref [CH];
  logic signed [N-1:0] r_y   [CH];
  logic signed [N-1:0] r_yp  [CH];
  logic signed [N-1:0] r_int [CH];
  logic signed [N-1:0] r_out [CH];
  logic signed [N-1:0] r_kp, r_ki, r_kd, r_max, r_min;

  logic signed [W-1:0] r_pi, r_pp, r_pd;
  logic signed [W-1:0] w_e, w_dy, w_pi, w_pp, w_pd;
  logic signed [W-1:0] w_isum, w_usum;
  logic signed [N-1:0] w_yc, w_inew, w_u;

  function automatic logic signed [W-1:0] sx(
    input logic signed [N-1:0] x
  );
    return {{(W-N){x[N-1]}}, x};
  endfunction

  function automatic logic signed [N-1:0] clampf(
    input logic signed [W-1:0] x
  );
    if (x > sx(r_max)) return r_max;
    if (x < sx(r_min)) return r_min;
    return x[N-1:0];
  endfunction

  // Debounce-style filter: only a stable level on both stages flips filt.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_filt   <= 1'b0;
      r_filt_q <= 1'b0;
    end else begin
      r_s1     <= sample_en;
      r_s2     <= r_s1;
      r_filt_q <= r_filt;
      if (r_s1 && r_s2)
        r_filt <= 1'b1;
      else if (!r_s1 && !r_s2)
        r_filt <= 1'b0;
    end
  end

  assign w_tick = r_filt & ~r_filt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_tick) w_next = S_CAPT;
      S_CAPT: w_next = S_MUL;
      S_MUL:  w_next = S_ACC;
      S_ACC:  w_next = (r_ch == CW'(CH-1)) ? S_DONE : S_MUL;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_yc   = r_y[r_ch];
  assign w_e    = sx(r_ref[r_ch]) - sx(w_yc);
  assign w_dy   = sx(w_yc) - sx(r_yp[r_ch]);
  assign w_pi   = (sx(r_ki) * w_e) >>> FRAC;
  assign w_pp   = (sx(r_kp) * sx(w_yc)) >>> FRAC;
  assign w_pd   = r_primed ? ((sx(r_kd) * w_dy) >>> FRAC) : '0;
  assign w_isum = sx(r_int[r_ch]) + r_pi;
  assign w_inew = clampf(w_isum);
  assign w_usum = sx(w_inew) - r_pp - r_pd;
  assign w_u    = clampf(w_usum);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ch     <= '0;
      r_primed <= 1'b0;
      overrun  <= 1'b0;
      r_kp     <= '0;
      r_ki     <= '0;
      r_kd     <= '0;
      r_max    <= '0;
      r_min    <= '0;
      r_pi     <= '0;
      r_pp     <= '0;
      r_pd     <= '0;
      for (int c = 0; c < CH; c++) begin
        r_ref[c] <= '0;
        r_y[c]   <= '0;
        r_yp[c]  <= '0;
        r_int[c] <= '0;
        r_out[c] <= '0;
      end
    end else begin
      if (w_tick && r_state != S_IDLE)
        overrun <= 1'b1;
      unique case (r_state)
        S_CAPT: begin
          r_ch  <= '0;
          r_kp  <= kp;
          r_ki  <= ki;
          r_kd  <= kd;
          r_max <= out_max;
          r_min <= out_min;
          for (int c = 0; c < CH; c++) begin
            r_ref[c] <= ref_in[c*N +: N];
            r_y[c]   <= y_in[c*N +: N];
          end
        end
        S_MUL: begin
          r_pi <= w_pi;
          r_pp <= w_pp;
          r_pd <= w_pd;
        end
        S_ACC: begin
          r_int[r_ch] <= w_inew;
          r_out[r_ch] <= w_u;
          r_yp[r_ch]  <= w_yc;
          r_ch        <= r_ch + CW'(1);
        end
        S_DONE: r_primed <= 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    ipd_out = '0;
    for (int c = 0; c < CH; c++)
      ipd_out[c*N +: N] = r_out[c];
  end

  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);

endmodule
